// File: rtl/alu_issue.sv
// MIPS execute-stage front end: decodes an instruction bundle into ALU control and
// operands (S1), then captures the ALU result and branch outcome for writeback (S2).
module alu_issue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  output logic [DATA_W-1:0] alu_data1,
  output logic [DATA_W-1:0] alu_data2,
  output logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [4:0]        out_rd,
  output logic              out_we,
  output logic              out_taken,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [3:0] CtrlAnd = 4'b0000;
  localparam logic [3:0] CtrlOr  = 4'b0001;
  localparam logic [3:0] CtrlAdd = 4'b0010;
  localparam logic [3:0] CtrlSub = 4'b0110;
  localparam logic [3:0] CtrlSlt = 4'b0111;
  localparam logic [3:0] CtrlXor = 4'b1100;
  localparam logic [3:0] CtrlNop = 4'b1111;

  typedef enum logic [1:0] {BrNone, BrEq, BrNe} br_e;

  logic        s1_valid;
  logic [4:0]  s1_rd;
  logic        s1_we;
  br_e         s1_br;
  logic        s2_valid;

  logic        s2_adv;
  logic        s1_adv;
  logic        s1_fire;
  logic        accept;

  logic [5:0]        op;
  logic [5:0]        funct;
  logic [3:0]        dec_ctrl;
  logic [DATA_W-1:0] dec_data2;
  logic [4:0]        dec_rd;
  logic              dec_we;
  br_e               dec_br;

  assign op    = in_instr[31:26];
  assign funct = in_instr[5:0];

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  // A flushed S1 entry must never reach S2.
  assign s1_fire  = s1_adv && !flush;
  assign in_ready = !flush && (!s1_valid || s2_adv);
  assign accept   = in_valid && in_ready;
  assign out_valid = s2_valid;

  // Decode opcode/funct into ALU control, operand B select, destination and branch type.
  always_comb begin
    dec_ctrl  = CtrlNop;
    dec_data2 = in_rt_data;
    dec_rd    = in_instr[20:16];
    dec_we    = 1'b0;
    dec_br    = BrNone;
    unique case (op)
      6'b000000: begin
        dec_rd = in_instr[15:11];
        dec_we = 1'b1;
        case (funct)
          6'b100000, 6'b100001: dec_ctrl = CtrlAdd;
          6'b100010, 6'b100011: dec_ctrl = CtrlSub;
          6'b100100:            dec_ctrl = CtrlAnd;
          6'b100101:            dec_ctrl = CtrlOr;
          6'b100110:            dec_ctrl = CtrlXor;
          6'b101010:            dec_ctrl = CtrlSlt;
          default:              dec_we   = 1'b0;
        endcase
      end
      6'b001000, 6'b001001, 6'b001010: begin
        dec_ctrl  = (op == 6'b001010) ? CtrlSlt : CtrlAdd;
        dec_data2 = {{(DATA_W-16){in_instr[15]}}, in_instr[15:0]};
        dec_we    = 1'b1;
      end
      6'b001100, 6'b001101, 6'b001110: begin
        dec_ctrl  = (op == 6'b001100) ? CtrlAnd : (op == 6'b001101) ? CtrlOr : CtrlXor;
        dec_data2 = {{(DATA_W-16){1'b0}}, in_instr[15:0]};
        dec_we    = 1'b1;
      end
      6'b000100, 6'b000101: begin
        dec_ctrl = CtrlSub;
        dec_br   = (op == 6'b000100) ? BrEq : BrNe;
      end
      default: ;
    endcase
    // Writes to $zero are discarded.
    if (dec_rd == 5'd0) dec_we = 1'b0;
  end

  // S1: operand/control register feeding the ALU.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      alu_data1 <= '0;
      alu_data2 <= '0;
      alu_ctrl  <= CtrlNop;
      s1_rd     <= '0;
      s1_we     <= 1'b0;
      s1_br     <= BrNone;
    end else if (flush) begin
      s1_valid <= 1'b0;
      alu_ctrl <= CtrlNop;
    end else if (accept) begin
      s1_valid  <= 1'b1;
      alu_data1 <= in_rs_data;
      alu_data2 <= dec_data2;
      alu_ctrl  <= dec_ctrl;
      s1_rd     <= dec_rd;
      s1_we     <= dec_we;
      s1_br     <= dec_br;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
      alu_ctrl <= CtrlNop;
    end
  end

  // S2: result register handed to writeback, plus the retirement counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid   <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
      out_we     <= 1'b0;
      out_taken  <= 1'b0;
      retired    <= '0;
    end else begin
      if (s1_fire) begin
        s2_valid   <= 1'b1;
        out_result <= alu_result;
        out_rd     <= s1_rd;
        out_we     <= s1_we;
        out_taken  <= (s1_br == BrEq) ? alu_zero : (s1_br == BrNe) ? !alu_zero : 1'b0;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
      if (s2_valid && out_ready) retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
